// File: rtl/pcle_cnt_reg.sv
// Loadable wrap counter with registered carry-out and a
// saturating pending-wrap event queue with sticky overflow.
module pcle_cnt_reg #(
  parameter int WIDTH    = 8,
  parameter int PEND_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ld,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             co,
  output logic             tc_valid,
  input  logic             tc_ready,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [3:0] PMAX = 4'(PEND_MAX);

  logic [WIDTH-1:0] r_cnt;
  logic             r_co;
  logic [3:0]       r_p;
  logic             r_tcv;
  logic             r_ovf;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap;
  logic             w_pop;
  logic [3:0]       w_p_nxt;
  logic             w_ovf_set;

  assign w_wrap = ce & ~ld & en & ~clr & (&r_cnt);
  assign w_pop  = r_tcv & tc_ready;

  // Counter next state: load beats count, anything else clears.
  always_comb begin
    w_cnt_nxt = '0;
    if (ld)
      w_cnt_nxt = din;
    else if (en && !clr)
      w_cnt_nxt = r_cnt + WIDTH'(1);
  end

  // Pending count: wrap pushes, accepted pop drains, both cancel.
  always_comb begin
    w_p_nxt   = r_p;
    w_ovf_set = 1'b0;
    if (w_wrap && !w_pop) begin
      if (r_p == PMAX)
        w_ovf_set = 1'b1;
      else
        w_p_nxt = r_p + 4'd1;
    end else if (!w_wrap && w_pop) begin
      w_p_nxt = r_p - 4'd1;
    end
  end

  // Counter and carry registers, gated by capture enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_co  <= 1'b0;
    end else begin
      if (ce)
        r_cnt <= w_cnt_nxt;
      r_co <= w_wrap;
    end
  end

  // Event logic runs regardless of ce so pops always complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= 4'd0;
      r_tcv <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_p   <= w_p_nxt;
      r_tcv <= (w_p_nxt != 4'd0);
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign cnt      = r_cnt;
  assign co       = r_co;
  assign tc_valid = r_tcv;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_pcle_cnt_reg.sv
// Scoreboard bench: directed vectors on the 8-bit counter, then
// random traffic on 8-bit and 4-bit instances against a model.
module tb_pcle_cnt_reg;

  typedef struct packed {
    logic [15:0] tag;
    logic [7:0]  c8;
    logic        co8, tv8, ov8;
    logic [3:0]  c4;
    logic        co4, tv4, ov4;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, ce = 1'b0, ld = 1'b0, en = 1'b0, clr = 1'b0;
  logic rdy = 1'b0, oclr = 1'b0;
  logic [7:0] d8 = 8'h00;

  logic [7:0] c8;
  logic       co8, tv8, ov8;
  logic [3:0] c4;
  logic       co4, tv4, ov4;

  int checks = 0;
  int fails  = 0;
  exp_t q[$];
  int tagn = 0;

  always #5 clk = ~clk;

  pcle_cnt_reg #(.WIDTH(8), .PEND_MAX(3)) u8 (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld), .en(en), .clr(clr),
    .din(d8), .cnt(c8), .co(co8), .tc_valid(tv8),
    .tc_ready(rdy), .ovf(ov8), .ovf_clr(oclr)
  );

  pcle_cnt_reg #(.WIDTH(4), .PEND_MAX(3)) u4 (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld), .en(en), .clr(clr),
    .din(d8[3:0]), .cnt(c4), .co(co4), .tc_valid(tv4),
    .tc_ready(rdy), .ovf(ov4), .ovf_clr(oclr)
  );

  task automatic chk(input string nm, input int tag,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", nm, tag, got, exp);
    end
  endtask

  // Monitor: outputs settle after each edge; compare the oldest entry.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cnt8", int'(e.tag), c8, e.c8);
      chk("co8", int'(e.tag), {7'd0, co8}, {7'd0, e.co8});
      chk("tv8", int'(e.tag), {7'd0, tv8}, {7'd0, e.tv8});
      chk("ovf8", int'(e.tag), {7'd0, ov8}, {7'd0, e.ov8});
      if (e.full) begin
        chk("cnt4", int'(e.tag), {4'd0, c4}, {4'd0, e.c4});
        chk("co4", int'(e.tag), {7'd0, co4}, {7'd0, e.co4});
        chk("tv4", int'(e.tag), {7'd0, tv4}, {7'd0, e.tv4});
        chk("ovf4", int'(e.tag), {7'd0, ov4}, {7'd0, e.ov4});
      end
    end
  end

  task automatic st(input logic rs, c, l, e, cl, r, oc,
                    input logic [7:0] d, input logic [7:0] ecnt,
                    input logic eco, etv, eov);
    exp_t x;
    @(negedge clk);
    rst = rs; ce = c; ld = l; en = e; clr = cl;
    rdy = r; oclr = oc; d8 = d;
    x = '0;
    x.tag = 16'(tagn); x.c8 = ecnt;
    x.co8 = eco; x.tv8 = etv; x.ov8 = eov;
    tagn++;
    q.push_back(x);
  endtask

  task automatic mstep(input int mask, input logic rs, c, l, e, cl,
                       input logic r, oc, input int d,
                       inout int mc, inout bit mco,
                       inout int mp, inout bit mov);
    bit wrap, pop;
    if (rs) begin
      mc = 0; mco = 0; mp = 0; mov = 0;
      return;
    end
    wrap = c && !l && e && !cl && (mc == mask);
    pop  = (mp != 0) && r;
    if (c)
      mc = l ? (d & mask) : (e && !cl) ? ((mc + 1) & mask) : 0;
    mco = wrap;
    if (wrap && !pop && mp == 3) mov = 1;
    else if (oc) mov = 0;
    if (wrap && !pop) begin
      if (mp < 3) mp++;
    end else if (pop && !wrap) begin
      mp--;
    end
  endtask

  initial begin
    int  mc8, mp8, mc4, mp4;
    bit  mco8, mov8, mco4, mov4;
    exp_t x;
    logic rs, c, l, e, cl, r, oc;
    logic [7:0] d;

    // reset       rs c l e cl r oc din    cnt   co tv ov
    st(1,0,0,0,0,0,0, 8'h00, 8'h00, 0,0,0);
    // load then count through the wrap
    st(0,1,1,0,0,0,0, 8'hFD, 8'hFD, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'hFE, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'hFF, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,0,1,0,1,0, 8'h00, 8'h01, 0,0,0);
    // priority and capture enable
    st(0,1,1,1,1,0,0, 8'h5A, 8'h5A, 0,0,0);
    st(0,1,0,1,1,0,0, 8'h77, 8'h00, 0,0,0);
    st(0,0,0,1,0,0,0, 8'h00, 8'h00, 0,0,0);
    st(0,1,1,0,0,0,0, 8'h33, 8'h33, 0,0,0);
    st(0,0,0,1,0,0,0, 8'h00, 8'h33, 0,0,0);
    st(0,0,1,1,0,0,0, 8'hFF, 8'h33, 0,0,0);
    // handshake: two wraps, wrap+pop, drain
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,1,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,1,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,0,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,0,0);
    // overflow: four wraps without pops
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,1);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,1);
    st(0,1,0,1,0,0,1, 8'h00, 8'h00, 1,1,1);
    st(0,1,0,0,0,0,1, 8'h00, 8'h00, 0,1,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,1,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,1,0);
    st(0,1,0,0,0,1,0, 8'h00, 8'h00, 0,0,0);
    // reset during a wrap with p=2 and ovf set
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,0);
    st(0,1,1,0,0,0,0, 8'hFF, 8'hFF, 0,1,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h00, 1,1,1);
    st(0,1,1,0,0,1,0, 8'hFF, 8'hFF, 0,1,1);
    st(1,1,0,1,0,0,0, 8'h00, 8'h00, 0,0,0);
    st(0,1,0,1,0,0,0, 8'h00, 8'h01, 0,0,0);

    // random phase: both widths against the model
    mc8 = 0; mp8 = 0; mco8 = 0; mov8 = 0;
    mc4 = 0; mp4 = 0; mco4 = 0; mov4 = 0;
    st(1,0,0,0,0,0,0, 8'h00, 8'h00, 0,0,0);
    for (int i = 0; i < 10000; i++) begin
      rs = ($urandom_range(499) == 0);
      c  = ($urandom_range(7) != 0);
      l  = ($urandom_range(15) == 0);
      e  = ($urandom_range(7) != 0);
      cl = ($urandom_range(15) == 0);
      r  = ($urandom_range(2) == 0);
      oc = ($urandom_range(15) == 0);
      d  = 8'($urandom);
      mstep(255, rs, c, l, e, cl, r, oc, int'(d),
            mc8, mco8, mp8, mov8);
      mstep(15, rs, c, l, e, cl, r, oc, int'(d),
            mc4, mco4, mp4, mov4);
      @(negedge clk);
      rst = rs; ce = c; ld = l; en = e; clr = cl;
      rdy = r; oclr = oc; d8 = d;
      x = '0;
      x.tag = 16'(tagn); tagn++;
      x.c8 = 8'(mc8); x.co8 = mco8;
      x.tv8 = (mp8 != 0); x.ov8 = mov8;
      x.c4 = 4'(mc4); x.co4 = mco4;
      x.tv4 = (mp4 != 0); x.ov4 = mov4;
      x.full = 1'b1;
      q.push_back(x);
    end

    @(negedge clk);
    rst = 1'b0; ce = 1'b0; ld = 1'b0; en = 1'b0; rdy = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pcle_cnt_reg.md
PCLE_CNT_REG -- requirements
Module: pcle_cnt_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits.
REQ-002 SHALL have parameter PEND_MAX, default 3, saturation limit of the pending wrap-event counter (1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port ce  input  1  capture enable; 0 = every register except the event logic holds.
REQ-006 SHALL have port ld  input  1  parallel load request.
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port clr  input  1  count inhibit / clear.
REQ-009 SHALL have port din  input  WIDTH  parallel load data.
REQ-010 SHALL have port cnt  output  WIDTH  registered counter state, fed back to the next-state stage.
REQ-011 SHALL have port co  output  1  registered carry-out pulse.
REQ-012 SHALL have port tc_valid  output  1  wrap event pending.
REQ-013 SHALL have port tc_ready  input  1  consumer accepts one wrap event.
REQ-014 SHALL have port ovf  output  1  sticky wrap-event overflow flag.
REQ-015 SHALL have port ovf_clr  input  1  clears ovf.

Function
REQ-016 SHALL compute next state per cycle with priority: ld -> din; else en=1 and clr=0 -> cnt+1 modulo 2^WIDTH; else -> 0.
REQ-017 SHALL update cnt with the next state only on cycles where ce=1; ce=0 holds cnt, co forced 0.
REQ-018 SHALL define a wrap as ce=1, ld=0, en=1, clr=0, cnt=all-ones.
REQ-019 SHALL drive co=1 for exactly the one cycle following a wrap (co registered; cnt=0 in that cycle), else 0.
REQ-020 SHALL ignore din unless ld=1; ld with cnt=all-ones is not a wrap.
REQ-021 SHALL keep a pending counter p, range 0..PEND_MAX; tc_valid = (p != 0), registered.
REQ-022 SHALL increment p on a wrap, decrement p on tc_valid and tc_ready, leave p unchanged when both occur same cycle.
REQ-023 SHALL ignore tc_ready when tc_valid=0 (no underflow).
REQ-024 SHALL, on a wrap with p=PEND_MAX and no accepted pop that cycle, hold p at PEND_MAX and set ovf on the next edge.
REQ-025 SHALL clear ovf on ovf_clr=1; a simultaneous new overflow wins (ovf stays/becomes 1).
REQ-026 SHALL update p, tc_valid, ovf independently of ce (ce=0 produces no wrap but pops still complete).
REQ-027 SHALL make the p increment and the cnt wrap-to-0 visible on the same clock edge; latency wrap -> tc_valid = 1 cycle.
REQ-028 SHALL keep all outputs glitch-free registered values; no combinational input-to-output path.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, set cnt=0, co=0, p=0, tc_valid=0, ovf=0, overriding all other inputs.
REQ-030 SHALL, on reset mid-operation, discard pending events and any in-flight carry; first post-reset cycle behaves as from power-up.

Verification
REQ-031 SHALL test load/count: ld=1 din=0xFD, then en=1 three cycles -> cnt 0xFD,0xFE,0xFF,0x00; co=1 only with cnt=0x00; tc_valid=1 next.
REQ-032 SHALL test priority: ld=1 en=1 clr=1 din=0x5A -> cnt=0x5A; then ld=0 en=1 clr=1 -> cnt=0x00; then ce=0 with en=1 -> cnt holds 0x00.
REQ-033 SHALL test handshake: 2 wraps with tc_ready=0 -> p=2; tc_ready=1 with a simultaneous wrap -> p stays 2; two more ready cycles -> tc_valid=0.
REQ-034 SHALL test overflow: 4 wraps, tc_ready=0, PEND_MAX=3 -> p=3, ovf=1 after 4th; ovf_clr=1 concurrent with a 5th wrap -> ovf stays 1; ovf_clr alone -> ovf=0.
REQ-035 SHALL test reset mid-run: cnt=0xFF, p=2, ovf=1, assert rst during wrap cycle -> cnt=0, co=0, tc_valid=0, ovf=0 next cycle.
REQ-036 SHALL check cnt against a reference model mod 2^WIDTH under random ld/en/clr/ce/tc_ready for >=10000 cycles, WIDTH=8 and WIDTH=4.
